// File: rtl/pipe_pkg.sv
// ---------------------------------------------------------------------------
// pipe_pkg
// Shared constants and types for the 3-stage arithmetic pipeline and the
// result FIFO that sits behind it.
//   PIPE_W        : width of the pipeline's signed result Y
//   PIPE_LAT      : in_valid-to-out_valid latency of the pipeline
//   AF_MARGIN_DEF : default almost-full margin (pipeline latency + 1)
//   DROP_CNT_W    : width of the saturating dropped-result counter
//   FIFO_DEPTH    : default number of result FIFO entries
// ---------------------------------------------------------------------------
package pipe_pkg;

    localparam int PIPE_W        = 16;
    localparam int PIPE_LAT      = 4;
    localparam int AF_MARGIN_DEF = PIPE_LAT + 1;
    localparam int DROP_CNT_W    = 8;
    localparam int FIFO_DEPTH    = 8;

    localparam logic [DROP_CNT_W-1:0] DROP_CNT_MAX = '1;

    // Overflow bookkeeping kept together so it moves as one register.
    typedef struct packed {
        logic                  ovf;
        logic [DROP_CNT_W-1:0] drop_cnt;
    } drop_state_t;

    // Increment that sticks at the all-ones value instead of wrapping.
    function automatic logic [DROP_CNT_W-1:0] sat_inc(input logic [DROP_CNT_W-1:0] v);
        if (v == DROP_CNT_MAX) begin
            return v;
        end
        return v + DROP_CNT_W'(1);
    endfunction

endpackage

// File: rtl/pipe_result_fifo_if.sv
// ---------------------------------------------------------------------------
// pipe_result_fifo_if
// Bundles the result FIFO's data-path and status signals.
//   in_valid/in_data     : result strobe and data from the pipeline
//   out_valid/out_data   : head entry presented to the consumer
//   out_ready            : consumer accepts the head this cycle
//   level/full/almost_full : fill status
//   ovf/drop_cnt/clr_ovf : overflow reporting and its clear
// The slave modport is the FIFO itself; master is the surrounding system.
// ---------------------------------------------------------------------------
interface pipe_result_fifo_if
    import pipe_pkg::*;
#(
    parameter int WIDTH = PIPE_W,
    parameter int DEPTH = FIFO_DEPTH
) ();

    logic                    in_valid;
    logic [WIDTH-1:0]        in_data;
    logic                    out_valid;
    logic [WIDTH-1:0]        out_data;
    logic                    out_ready;
    logic [$clog2(DEPTH):0]  level;
    logic                    full;
    logic                    almost_full;
    logic                    ovf;
    logic [DROP_CNT_W-1:0]   drop_cnt;
    logic                    clr_ovf;

    modport master (
        output in_valid, in_data, out_ready, clr_ovf,
        input  out_valid, out_data, level, full, almost_full, ovf, drop_cnt
    );

    modport slave (
        input  in_valid, in_data, out_ready, clr_ovf,
        output out_valid, out_data, level, full, almost_full, ovf, drop_cnt
    );

endinterface

// File: rtl/pipe_fifo_mem.sv
// ---------------------------------------------------------------------------
// pipe_fifo_mem
// DEPTH x WIDTH register array used as FIFO storage.
//   clk   : write clock
//   we    : write enable
//   waddr : write address
//   wdata : write data
//   raddr : read address (asynchronous read)
//   rdata : contents of entry raddr
// The array is not reset; the FIFO's pointers decide what is meaningful.
// ---------------------------------------------------------------------------
module pipe_fifo_mem #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 8,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic [AW-1:0]    raddr,
    output logic [WIDTH-1:0] rdata
);

    logic [WIDTH-1:0] mem_q [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[waddr] <= wdata;
        end
    end

    assign rdata = mem_q[raddr];

endmodule

// File: rtl/pipe_result_fifo.sv
// ---------------------------------------------------------------------------
// pipe_result_fifo
// First-word fall-through buffer for the pipeline's result stream. The
// pipeline cannot be stalled, so every valid result is absorbed here when
// there is room and counted as dropped when there is not.
//   clk : clock, rising edge
//   rst : synchronous, active-high reset (flushes all entries)
//   bus : pipe_result_fifo_if slave port
//         in_valid/in_data   - result stream from the pipeline
//         out_valid/out_data - head entry, out_data is 0 when empty
//         out_ready          - consumer pops the head
//         level/full/almost_full - fill status from the registered level
//         ovf/drop_cnt/clr_ovf   - sticky overflow flag, saturating count
// ---------------------------------------------------------------------------
module pipe_result_fifo
    import pipe_pkg::*;
#(
    parameter int WIDTH     = PIPE_W,
    parameter int DEPTH     = FIFO_DEPTH,
    parameter int AF_MARGIN = AF_MARGIN_DEF
) (
    input  logic               clk,
    input  logic               rst,
    pipe_result_fifo_if.slave  bus
);

    localparam int PTR_W     = $clog2(DEPTH);
    localparam int LVL_W     = PTR_W + 1;
    localparam int AF_THRESH = DEPTH - AF_MARGIN;

    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [LVL_W-1:0] level_q, level_d;
    drop_state_t      drop_q, drop_d;

    logic             not_empty;
    logic             is_full;
    logic             almost_full;
    logic             push;
    logic             pop;
    logic             drop;
    logic             mem_we;
    logic [WIDTH-1:0] head_data;

    // A full FIFO may still accept a result when the head leaves in the
    // same cycle; otherwise an incoming result on a full FIFO is dropped.
    always_comb begin
        not_empty = (level_q != '0);
        is_full   = (level_q == LVL_W'(DEPTH));
        pop       = not_empty & bus.out_ready;
        push      = bus.in_valid & (~is_full | pop);
        drop      = bus.in_valid & is_full & ~pop;
        mem_we    = push & ~rst;
    end

    // A threshold at or below zero means the flag is permanently raised.
    generate
        if (AF_THRESH <= 0) begin : g_af_const
            assign almost_full = 1'b1;
        end else begin : g_af_cmp
            assign almost_full = (level_q >= LVL_W'(AF_THRESH));
        end
    endgenerate

    // Pointer, level and overflow next-state. Simultaneous clear and drop
    // resolves in favour of the drop so the new loss is never hidden.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        drop_d   = drop_q;

        if (push) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end

        if (push && !pop) begin
            level_d = level_q + LVL_W'(1);
        end else if (pop && !push) begin
            level_d = level_q - LVL_W'(1);
        end

        if (drop) begin
            drop_d.ovf = 1'b1;
            if (bus.clr_ovf) begin
                drop_d.drop_cnt = DROP_CNT_W'(1);
            end else begin
                drop_d.drop_cnt = sat_inc(drop_q.drop_cnt);
            end
        end else if (bus.clr_ovf) begin
            drop_d.ovf      = 1'b0;
            drop_d.drop_cnt = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
            drop_q   <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
            drop_q   <= drop_d;
        end
    end

    pipe_fifo_mem #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_mem (
        .clk   (clk),
        .we    (mem_we),
        .waddr (wr_ptr_q),
        .wdata (bus.in_data),
        .raddr (rd_ptr_q),
        .rdata (head_data)
    );

    // Head is forced to zero when empty so stale storage never leaks out.
    always_comb begin
        bus.out_valid   = not_empty;
        bus.out_data    = not_empty ? head_data : '0;
        bus.level       = level_q;
        bus.full        = is_full;
        bus.almost_full = almost_full;
        bus.ovf         = drop_q.ovf;
        bus.drop_cnt    = drop_q.drop_cnt;
    end

endmodule

// File: tb/tb_pipe_result_fifo.sv
// ---------------------------------------------------------------------------
// tb_pipe_result_fifo
// Directed, table-driven bench for pipe_result_fifo (WIDTH=16, DEPTH=8,
// AF_MARGIN=5, so almost_full rises at level 3). Inputs change 1 ns after a
// rising edge and outputs are sampled there, between edges.
// ---------------------------------------------------------------------------
module tb_pipe_result_fifo;

    localparam int W = 16;
    localparam int D = 8;

    logic clk;
    logic rst;

    pipe_result_fifo_if #(.WIDTH(W), .DEPTH(D)) bus ();

    pipe_result_fifo #(.WIDTH(W), .DEPTH(D), .AF_MARGIN(5)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        r;
        logic        iv;
        logic [15:0] d;
        logic        rdy;
        logic        clr;
        logic        ev;
        logic [15:0] ed;
        logic [3:0]  el;
        logic        eo;
        logic [7:0]  edc;
    } vec_t;

    vec_t vecs[$];
    int   total = 0;
    int   bad   = 0;

    function automatic void add(input logic r, input logic iv, input int d,
                                input logic rdy, input logic clr,
                                input logic ev, input int ed, input int el,
                                input logic eo, input int edc);
        vec_t v;
        v.r = r; v.iv = iv; v.d = 16'(d); v.rdy = rdy; v.clr = clr;
        v.ev = ev; v.ed = 16'(ed); v.el = 4'(el); v.eo = eo; v.edc = 8'(edc);
        vecs.push_back(v);
    endfunction

    // Drive one cycle of inputs and step to just after the next rising edge.
    task automatic applyStimulus(input logic r, input logic iv, input logic [15:0] d,
                                 input logic rdy, input logic clr);
        rst           = r;
        bus.in_valid  = iv;
        bus.in_data   = d;
        bus.out_ready = rdy;
        bus.clr_ovf   = clr;
        @(posedge clk);
        #1;
    endtask

    // Full/almost-full expectations come from the expected level.
    task automatic checkOutput(input string name, input logic ev, input logic [15:0] ed,
                               input logic [3:0] el, input logic eo, input logic [7:0] edc);
        logic ef, eaf;
        ef  = (el == 4'd8);
        eaf = (el >= 4'd3);
        total++;
        if ({bus.out_valid, bus.out_data, bus.level, bus.full, bus.almost_full, bus.ovf, bus.drop_cnt}
            !== {ev, ed, el, ef, eaf, eo, edc}) begin
            bad++;
            $display("[TB] FAIL %s: got v=%0b d=%0d lvl=%0d f=%0b af=%0b ovf=%0b drop=%0d, want v=%0b d=%0d lvl=%0d f=%0b af=%0b ovf=%0b drop=%0d",
                     name, bus.out_valid, bus.out_data, bus.level, bus.full, bus.almost_full,
                     bus.ovf, bus.drop_cnt, ev, ed, el, ef, eaf, eo, edc);
        end
    endtask

    task automatic checkVal(input string name, input int act, input int exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %0d, want %0d", name, act, exp);
        end
    endtask

    initial begin
        int heads[7] = '{3, 4, 5, 6, 7, 8, 42};
        logic [15:0] q[$];
        int pushed, received, cyc;
        logic rdy, iv, do_pop;

        rst = 1'b1; bus.in_valid = 1'b0; bus.in_data = '0;
        bus.out_ready = 1'b0; bus.clr_ovf = 1'b0;

        // reset
        add(1, 0, 0, 0, 0,   0, 0, 0, 0, 0);
        // single push / pop
        add(0, 1, 23, 1, 0,  1, 23, 1, 0, 0);
        add(0, 0, 0, 1, 0,   0, 0, 0, 0, 0);
        // fill with consumer stalled
        for (int k = 1; k <= 8; k++) add(0, 1, k, 0, 0,  1, 1, k, 0, 0);
        // overflow: 99 dropped
        add(0, 1, 99, 0, 0,  1, 1, 8, 1, 1);
        // full with simultaneous pop: 1 leaves, 42 enters
        add(0, 1, 42, 1, 0,  1, 2, 8, 1, 1);
        // drain
        for (int j = 1; j <= 7; j++) add(0, 0, 0, 1, 0,  1, heads[j-1], 8 - j, 1, 1);
        add(0, 0, 0, 1, 0,   0, 0, 0, 1, 1);
        // clear alone
        add(0, 0, 0, 0, 1,   0, 0, 0, 0, 0);
        // refill, three drops, then clear racing a drop
        for (int k = 0; k < 8; k++) add(0, 1, 10 + k, 0, 0,  1, 10, k + 1, 0, 0);
        for (int k = 1; k <= 3; k++) add(0, 1, 200, 0, 0,  1, 10, 8, 1, k);
        add(0, 1, 201, 0, 1,  1, 10, 8, 1, 1);
        add(0, 0, 0, 0, 1,    1, 10, 8, 0, 0);
        // drain to level 5
        for (int k = 1; k <= 3; k++) add(0, 0, 0, 1, 0,  1, 10 + k, 8 - k, 0, 0);
        // reset mid-operation with a push in the same cycle
        add(1, 1, 55, 0, 0,  0, 0, 0, 0, 0);
        add(0, 1, 77, 0, 0,  1, 77, 1, 0, 0);
        add(0, 0, 0, 1, 0,   0, 0, 0, 0, 0);

        foreach (vecs[i]) begin
            applyStimulus(vecs[i].r, vecs[i].iv, vecs[i].d, vecs[i].rdy, vecs[i].clr);
            checkOutput($sformatf("vec%0d", i), vecs[i].ev, vecs[i].ed, vecs[i].el,
                        vecs[i].eo, vecs[i].edc);
        end

        // drop counter saturation
        for (int k = 1; k <= 8; k++) applyStimulus(0, 1, 16'(k), 0, 0);
        for (int n = 1; n <= 260; n++) begin
            applyStimulus(0, 1, 16'd300, 0, 0);
            if (n == 1)   checkVal("sat_first", int'(bus.drop_cnt), 1);
            if (n == 255) checkVal("sat_255",   int'(bus.drop_cnt), 255);
            if (n == 260) checkVal("sat_hold",  int'(bus.drop_cnt), 255);
        end
        checkVal("sat_level", int'(bus.level), 8);
        checkVal("sat_head",  int'(bus.out_data), 1);
        applyStimulus(1, 0, 16'd0, 0, 0);
        checkOutput("sat_reset", 0, 0, 0, 0, 0);

        // wrap with consumer toggling ready every cycle
        pushed = 0; received = 0; cyc = 0;
        while ((pushed < 20 || q.size() != 0) && cyc < 400) begin
            rdy    = cyc[0];
            iv     = (pushed < 20) && (q.size() < 6);
            do_pop = rdy && (q.size() != 0);
            if (do_pop) begin
                checkVal($sformatf("wrap_data%0d", received), int'(bus.out_data), int'(q[0]));
                received++;
            end
            applyStimulus(0, iv, 16'(23 + 6 * pushed), rdy, 0);
            if (do_pop) void'(q.pop_front());
            if (iv) begin
                q.push_back(16'(23 + 6 * pushed));
                pushed++;
            end
            checkVal($sformatf("wrap_level%0d", cyc), int'(bus.level), q.size());
            cyc++;
        end
        checkVal("wrap_count", received, 20);
        checkOutput("wrap_end", 0, 0, 0, 0, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
